// File: rtl/keypad_pkg.sv
// ============================================================================
// keypad_pkg : shared types and key map for the 4x4 matrix keypad scanner
// Revision   : 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    // Entry {row,col} lives at bits [4*{row,col} +: 4]; row 0 reads 1,2,3,A from col 0.
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [3:0] rc);
        return KEY_MAP[{rc, 2'b00} +: 4];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// sync2    : two-flop synchronizer for asynchronous level inputs
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// keypad_scanner : column-scanned 4x4 keypad reader with whole-scan debounce
// Revision       : 1.0
// ============================================================================
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [PW-1:0] c_PHASE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] c_CNT_DONE   = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] c_CNT_ONE    = CW'(1);
    localparam logic [1:0]    c_LAST_COL   = 2'(NUM_COLS - 1);

    logic [3:0]    row_sync;
    logic [PW-1:0] phase_q;
    logic [1:0]    col_idx_q;
    logic [15:0]   image_q;
    logic          sample;
    logic          eos;

    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row),
        .q_o   (row_sync)
    );

    assign sample = (phase_q == c_PHASE_LAST);
    assign eos    = sample && (col_idx_q == c_LAST_COL);
    assign col    = ~(4'b0001 << col_idx_q);

    // Image holds pressed (active-high) bits: bit 4*col + row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= '0;
            col_idx_q <= '0;
            image_q   <= '0;
        end else if (sample) begin
            phase_q                        <= '0;
            col_idx_q                      <= col_idx_q + 2'd1;
            image_q[{col_idx_q, 2'b00} +: 4] <= ~row_sync;
        end else begin
            phase_q <= phase_q + PW'(1);
        end
    end

    // Classification sees the column being sampled this cycle, not the stale nibble.
    logic [15:0] scan_img;
    logic [4:0]  hits;
    logic [3:0]  hit_rc;
    logic        cls_none;
    logic        cls_one;

    always_comb begin
        scan_img                          = image_q;
        scan_img[{col_idx_q, 2'b00} +: 4] = ~row_sync;
        hits                              = '0;
        hit_rc                            = '0;
        for (int i = 0; i < 16; i++) begin
            if (scan_img[i]) begin
                hits   = hits + 5'd1;
                hit_rc = {i[1:0], i[3:2]};
            end
        end
    end

    assign cls_none = (hits == 5'd0);
    assign cls_one  = (hits == 5'd1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = 1'b0;
        cnt_inc = (cnt_q == c_CNT_DONE) ? cnt_q : cnt_q + CW'(1);
        if (eos) begin
            case (state_q)
                ST_IDLE: begin
                    if (cls_one) begin
                        cand_d = hit_rc;
                        if (c_CNT_ONE == c_CNT_DONE) begin
                            state_d = ST_PRESSED;
                            valid_d = 1'b1;
                            code_d  = key_lookup(hit_rc);
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = c_CNT_ONE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!cls_one) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (hit_rc != cand_q) begin
                        cand_d = hit_rc;
                        cnt_d  = c_CNT_ONE;
                    end else if (cnt_inc == c_CNT_DONE) begin
                        state_d = ST_PRESSED;
                        valid_d = 1'b1;
                        code_d  = key_lookup(cand_q);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_PRESSED: begin
                    if (cls_none) begin
                        if (c_CNT_ONE == c_CNT_DONE) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_RELEASE;
                            cnt_d   = c_CNT_ONE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!cls_none) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_inc == c_CNT_DONE) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// tb_keypad_scanner : scan-level reference model against the keypad scanner
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    localparam int DS = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys_tb;     // bit 4*r + c : key (r,c) held
    logic [3:0]  kmap [16];   // indexed 4*r + c

    int n_total;
    int n_bad;

    // scan-level model state
    bit         held_m;
    bit         strobe_m;
    int         run_m;
    int         nrun_m;
    int         cand_m;
    logic [3:0] code_m;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && keys_tb[4*r + c]) row[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        held_m = 0; strobe_m = 0; run_m = 0; nrun_m = 0; cand_m = -1; code_m = 4'h0;
    endtask

    task automatic model_scan(input logic [15:0] keys);
        int n;
        int k;
        n = $countones(keys);
        k = -1;
        for (int b = 0; b < 16; b++) if (keys[b]) k = b;
        strobe_m = 0;
        if (!held_m) begin
            if (n == 1) begin
                if (run_m > 0 && k == cand_m) run_m++;
                else begin cand_m = k; run_m = 1; end
                if (run_m == DS) begin
                    held_m = 1; strobe_m = 1; code_m = kmap[k]; run_m = 0; nrun_m = 0;
                end
            end else begin
                run_m = 0;
            end
        end else if (n == 0) begin
            nrun_m++;
            if (nrun_m == DS) begin held_m = 0; nrun_m = 0; end
        end else begin
            nrun_m = 0;
        end
    endtask

    // Called at #1 after the edge that starts column 0, phase 0.
    task automatic run_scan(input logic [15:0] keys);
        logic [3:0] col_exp;
        keys_tb = keys;
        for (int i = 0; i < 16; i++) begin
            col_exp = 4'b0001 << (i / 4);
            check("col", col, ~col_exp);
            check("valid", {3'b0, key_valid}, {3'b0, (i == 0) ? strobe_m : 1'b0});
            check("held", {3'b0, key_held}, {3'b0, held_m});
            @(posedge clk); #1;
        end
        model_scan(keys);
        check("eos_valid", {3'b0, key_valid}, {3'b0, strobe_m});
        check("eos_code", key_code, code_m);
        check("eos_held", {3'b0, key_held}, {3'b0, held_m});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_col"}, col, 4'b1110);
        check({tag, "_valid"}, {3'b0, key_valid}, 4'h0);
        check({tag, "_held"}, {3'b0, key_held}, 4'h0);
        check({tag, "_code"}, key_code, 4'h0);
    endtask

    // Runs part of a scan, pulls reset between edges, then restarts scan alignment.
    task automatic reset_mid(input logic [15:0] keys, input int ncyc);
        keys_tb = keys;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_vals("in_rst");
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  tbl [16];
        logic [15:0] cur;
        int          sel;
        tbl = '{4'h1, 4'h2, 4'h3, 4'hA,
                4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC,
                4'h0, 4'hF, 4'hE, 4'hD};
        kmap    = tbl;
        n_total = 0;
        n_bad   = 0;
        keys_tb = '0;
        rst_n   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_vals("por");
        rst_n = 1'b1;

        // idle scans
        repeat (2) run_scan(16'h0000);

        // single key (r1,c2) held 20 scans, then released
        repeat (20) run_scan(16'h0001 << 6);
        repeat (5) run_scan(16'h0000);

        // bounce on (r3,c0), then steady
        for (int s = 0; s < 6; s++) run_scan((s % 2 == 0) ? (16'h0001 << 12) : 16'h0000);
        repeat (5) run_scan(16'h0001 << 12);
        repeat (4) run_scan(16'h0000);

        // ghost pair on row 0, then drop (r0,c1)
        repeat (4) run_scan(16'h0003);
        repeat (4) run_scan(16'h0001);
        repeat (4) run_scan(16'h0000);

        // roll-over: A then add D
        repeat (4) run_scan(16'h0001 << 3);
        repeat (4) run_scan((16'h0001 << 3) | (16'h0001 << 15));
        repeat (4) run_scan(16'h0000);

        // reset while debouncing
        repeat (2) run_scan(16'h0001 << 5);
        reset_mid(16'h0001 << 5, 6);
        repeat (4) run_scan(16'h0001 << 5);
        repeat (4) run_scan(16'h0000);

        // reset while pressed
        repeat (4) run_scan(16'h0001 << 9);
        reset_mid(16'h0001 << 9, 9);
        repeat (4) run_scan(16'h0001 << 9);
        repeat (4) run_scan(16'h0000);

        // randomized key activity
        cur = '0;
        for (int s = 0; s < 150; s++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 7)      cur = '0;
            else if (sel == 8) cur = 16'h0001 << $urandom_range(0, 15);
            else if (sel == 9) cur = (16'h0001 << $urandom_range(0, 15)) |
                                     (16'h0001 << $urandom_range(0, 15));
            run_scan(cur);
        end
        repeat (4) run_scan(16'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
